// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor. Each stage ripples one WIDTH/STAGES-bit segment per
// clock, carrying the untouched upper operand bits and the finished lower sum bits alongside.
module rca_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("rca_pipe_addsub: WIDTH must be >= 2 and an exact multiple of STAGES >= 1");
  end

  // Handshake: a beat enters on in_valid && in_ready and leaves on out_valid && out_ready.
  // The whole pipe (bubbles included) moves as one, so it only holds while a presented result
  // is refused; in_ready is therefore a combinational function of out_valid/out_ready.
  logic advance;
  logic out_valid_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // Subtraction is a + ~b + ~cin, so a borrow-in clears the injected carry.
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? ~cin : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO  = k * SEG;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]    a_in;
    logic [REM-1:0]    b_in;
    logic              c_in;
    logic              v_in;
    logic [SEG:0]      seg_res;
    logic [LO+SEG-1:0] s_done;

    assign seg_res = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

    if (k == 0) begin : g_head
      assign a_in   = a;
      assign b_in   = b_eff;
      assign c_in   = c0;
      assign v_in   = in_valid;
      assign s_done = seg_res[SEG-1:0];
    end else begin : g_body
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;
      logic [LO-1:0]  s_q;
      logic           c_q;
      logic           v_q;

      // Data only loads for real beats so bubbles leave no toggling behind them.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else if (advance) begin
          v_q <= g_stg[k-1].v_in;
          if (g_stg[k-1].v_in) begin
            a_q <= g_stg[k-1].a_in[REM+SEG-1:SEG];
            b_q <= g_stg[k-1].b_in[REM+SEG-1:SEG];
            s_q <= g_stg[k-1].s_done;
            c_q <= g_stg[k-1].seg_res[SEG];
          end
        end
      end

      assign a_in   = a_q;
      assign b_in   = b_q;
      assign c_in   = c_q;
      assign v_in   = v_q;
      assign s_done = {seg_res[SEG-1:0], s_q};
    end
  end

  // The last segment's ripple lands directly in the output registers.
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             a_msb;
  logic             b_msb;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  assign a_msb  = g_stg[LAST].a_in[SEG-1];
  assign b_msb  = g_stg[LAST].b_in[SEG-1];
  assign sum_d  = g_stg[LAST].s_done;
  assign cout_d = g_stg[LAST].seg_res[SEG];
  assign ovf_d  = (a_msb == b_msb) && (sum_d[WIDTH-1] != a_msb);

  // Result fields hold their last delivered value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (advance) begin
      out_valid_q <= g_stg[LAST].v_in;
      if (g_stg[LAST].v_in) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Bench for rca_pipe_addsub (WIDTH=32, STAGES=4): directed vectors with hand-computed results,
// stall, reset and backpressure streams, all checked through an expected-result queue.
module tb_rca_pipe_addsub;
  localparam int W      = 32;
  localparam int STAGES = 4;
  localparam int EW     = W + 2;
  localparam int NTV    = 12;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  // Expected results packed as {cout, ovf, sum}.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp;
  int unsigned   pass_cnt  = 0;
  int unsigned   total_cnt = 0;
  bit            stream_done;

  logic [W-1:0]  tv_a   [NTV] = '{32'hA0A0FFFF, 32'hFFFFFFFF, 32'h00000005, 32'h80000000,
                                  32'h00000001, 32'h7FFFFFFF, 32'h00000010, 32'h00000000,
                                  32'h0000FFFF, 32'h80000000, 32'h12345678, 32'h00000000};
  logic [W-1:0]  tv_b   [NTV] = '{32'hA0BFFFE0, 32'h00000000, 32'h00000007, 32'h00000001,
                                  32'h00000001, 32'h00000001, 32'h00000003, 32'h00000000,
                                  32'h00000001, 32'h80000000, 32'h87654321, 32'h80000000};
  logic          tv_cin [NTV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                                  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic          tv_sub [NTV] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [EW-1:0] tv_exp [NTV] = '{{1'b1, 1'b1, 32'h4160FFDF}, {1'b1, 1'b0, 32'h00000000},
                                  {1'b0, 1'b0, 32'hFFFFFFFE}, {1'b1, 1'b1, 32'h7FFFFFFF},
                                  {1'b0, 1'b0, 32'h00000003}, {1'b0, 1'b1, 32'h80000000},
                                  {1'b1, 1'b0, 32'h0000000C}, {1'b0, 1'b0, 32'hFFFFFFFF},
                                  {1'b0, 1'b0, 32'h00010000}, {1'b1, 1'b0, 32'h00000000},
                                  {1'b0, 1'b0, 32'h99999999}, {1'b0, 1'b1, 32'h80000000}};

  rca_pipe_addsub #(.WIDTH(W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic void check(input string name, input logic [EW-1:0] act,
                                input logic [EW-1:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endfunction

  function automatic logic [EW-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input logic cv, input logic sv);
    logic [W-1:0] be;
    logic         c0;
    logic [W:0]   r;
    logic         o;
    be = sv ? ~bv : bv;
    c0 = sv ? ~cv : cv;
    r  = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, c0};
    o  = (av[W-1] == be[W-1]) && (r[W-1] != av[W-1]);
    return {r[W], o, r[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h80000000;
      3:       return 32'h7FFFFFFF;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                      input logic sv, input logic [EW-1:0] e);
    bit fired;
    fired    = 1'b0;
    a        = av;
    b        = bv;
    cin      = cv;
    sub      = sv;
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !fired; t++) begin
      @(negedge clk);
      fired = in_ready;
      @(posedge clk);
      if (fired) exp_q.push_back(e);
      #1;
    end
    in_valid = 1'b0;
    if (!fired) check("send_accept", EW'(fired), EW'(1));
  endtask

  task automatic send_tv(input int i);
    send(tv_a[i], tv_b[i], tv_cin[i], tv_sub[i], tv_exp[i]);
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", EW'(exp_q.size()), EW'(0));
      exp_q.delete();
    end
    idle(2);
  endtask

  // Accept at edge N must show out_valid at the negedge following edge N+STAGES-1.
  task automatic latency_test(input string name, input int i);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    send_tv(i);
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      n++;
      if (out_valid) seen = 1'b1;
    end
    check(name, EW'(n), EW'(STAGES));
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [EW-1:0] got;
    got = {cout, ovf, sum};
    if (!rst_n) begin
      last_exp = '0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_beat: got %h while no result outstanding", got);
      end else if (out_ready) begin
        last_exp = exp_q.pop_front();
        check("result", got, last_exp);
      end else begin
        check("stall_hold", got, exp_q[0]);
      end
    end else begin
      check("bubble_hold", got, last_exp);
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", EW'(out_valid), EW'(0));
    check("reset_result",    {cout, ovf, sum}, '0);
    check("reset_in_ready",  EW'(in_ready),  EW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beats: latency and the headline vectors.
    latency_test("latency_add", 0);
    latency_test("latency_carry_chain", 1);
    latency_test("latency_sub", 2);
    drain();

    // All directed vectors back-to-back.
    for (int i = 0; i < NTV; i++) send_tv(i);
    drain();

    // Eight beats back-to-back with the output refused for three cycles.
    fork
      begin
        for (int i = 0; i < 8; i++) send_tv(i);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready",  EW'(in_ready),  EW'(0));
          check("stall_out_valid", EW'(out_valid), EW'(1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Long stream with random gaps and backpressure, mixed with the directed vectors.
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if (i % 4 == 0) begin
            send_tv((i / 4) % NTV);
          end else begin
            logic [W-1:0] av;
            logic [W-1:0] bv;
            logic         cv;
            logic         sv;
            av = rand_op();
            bv = rand_op();
            cv = 1'($urandom_range(0, 1));
            sv = 1'($urandom_range(0, 1));
            send(av, bv, cv, sv, model(av, bv, cv, sv));
          end
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight and a live result on the outputs.
    for (int i = 4; i < 9; i++) send_tv(i);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", EW'(out_valid), EW'(0));
    check("midreset_result",    {cout, ovf, sum}, '0);
    check("midreset_in_ready",  EW'(in_ready),  EW'(1));
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("post_reset_no_stale", EW'(out_valid), EW'(0));
    end
    @(posedge clk);
    #1;
    latency_test("latency_after_reset", 3);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
